// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver with a one-deep holding register,
// sticky framing/overrun flags and a registered interrupt output.
module uart_rx_core #(
    parameter int CLKS_PER_BIT = 4167,
    parameter int DATA_BITS    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_pop,
    input  logic       err_clr,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy,
    output logic       irq
);

    localparam logic [15:0] HALF_LIMIT = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_LIMIT = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_BIT   = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK_WAIT
    } state_t;

    state_t      state;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_reg;

    logic rx_meta;
    logic rx_s;
    logic rx_prev;

    logic fall_edge;
    logic stop_tick;
    logic good_stop;
    logic bad_stop;
    logic can_commit;

    // Two-flop synchronizer plus one history flop; idle-high reset values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    assign fall_edge  = !rx_s && rx_prev;
    assign stop_tick  = (state == STOP) && (baud_cnt == FULL_LIMIT);
    assign good_stop  = stop_tick && rx_s;
    assign bad_stop   = stop_tick && !rx_s;
    assign can_commit = !rx_valid || rx_pop;

    // Frame sequencer: start validation, mid-bit sampling, stop check, break wait
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            baud_cnt  <= 16'd0;
            bit_cnt   <= 3'd0;
            shift_reg <= 8'h00;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= 16'd0;
                    if (fall_edge) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (baud_cnt == HALF_LIMIT) begin
                        baud_cnt <= 16'd0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_cnt <= 3'd0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (baud_cnt == FULL_LIMIT) begin
                        baud_cnt  <= 16'd0;
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        if (bit_cnt == LAST_BIT) begin
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (baud_cnt == FULL_LIMIT) begin
                        baud_cnt <= 16'd0;
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= BREAK_WAIT;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                BREAK_WAIT: begin
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    baud_cnt <= 16'd0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    // Holding register: a good frame loads it when empty or being popped this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
        end else begin
            if (good_stop && can_commit) begin
                rx_data  <= shift_reg;
                rx_valid <= 1'b1;
            end else if (rx_pop && rx_valid) begin
                rx_valid <= 1'b0;
            end
        end
    end

    // Sticky error flags (a new error beats err_clr) and the registered interrupt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            irq       <= 1'b0;
        end else begin
            if (bad_stop) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
            if (good_stop && !can_commit) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end
            irq <= rx_valid | frame_err | overrun;
        end
    end

endmodule
